// File: rtl/tlm_pkg.sv
// Shared definitions for the traffic light monitor: lamp encodings, phase codes,
// error strobe bit positions and the monitor FSM state type.
package tlm_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [1:0] {
        PH_NS_G = 2'd0,
        PH_NS_Y = 2'd1,
        PH_EW_G = 2'd2,
        PH_EW_Y = 2'd3
    } phase_e;

    localparam int ERR_TIMING   = 0;
    localparam int ERR_SEQ      = 1;
    localparam int ERR_ILLEGAL  = 2;
    localparam int ERR_CONFLICT = 3;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } tlm_state_e;

endpackage

// File: rtl/tlm_phase_decode.sv
// Combinational decode of a registered {NS, EW} lamp sample into a phase code,
// a legal flag and the conflicting-greens condition.
module tlm_phase_decode
    import tlm_pkg::*;
(
    input  logic [5:0] lights_i,
    output logic [1:0] code_o,
    output logic       legal_o,
    output logic       conflict_o
);

    logic [2:0] ns;
    logic [2:0] ew;

    assign ns = lights_i[5:3];
    assign ew = lights_i[2:0];

    // Only the four controller states are legal; everything else, all-red included, is not.
    always_comb begin
        code_o  = PH_NS_G;
        legal_o = 1'b0;
        if (ns == LAMP_GRN && ew == LAMP_RED) begin
            code_o  = PH_NS_G;
            legal_o = 1'b1;
        end else if (ns == LAMP_YEL && ew == LAMP_RED) begin
            code_o  = PH_NS_Y;
            legal_o = 1'b1;
        end else if (ns == LAMP_RED && ew == LAMP_GRN) begin
            code_o  = PH_EW_G;
            legal_o = 1'b1;
        end else if (ns == LAMP_RED && ew == LAMP_YEL) begin
            code_o  = PH_EW_Y;
            legal_o = 1'b1;
        end
    end

    assign conflict_o = ~ns[2] & ~ew[2];

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker beside the intersection controller: flags conflicts, illegal
// encodings, out-of-order phases and (with TLM_TIMING_CHECK_EN) wrong dwell times.
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int PHASE_CYCLES = 11,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       light_north_south,
    input  logic [2:0]       light_east_west,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [3:0]       err_pulse,
    output logic [3:0]       err_status,
    output logic [CNT_W-1:0] round_count
);

`ifdef TLM_TIMING_CHECK_EN
    localparam logic [CNT_W-1:0] DWELL_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_NOM   = CNT_W'(PHASE_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LIMIT = CNT_W'(PHASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_MAX   = '1;

    logic [CNT_W-1:0] dwell_q, dwell_d, dwell_inc;
`endif

    logic [2:0]       ns_q, ew_q;
    tlm_state_e       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       next_phase;
    logic             first_partial_q, first_partial_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [3:0]       status_q, status_d;
    logic [CNT_W-1:0] round_q, round_d;

    logic [1:0]       code;
    logic             legal;
    logic             conflict;

    tlm_phase_decode u_decode (
        .lights_i   ({ns_q, ew_q}),
        .code_o     (code),
        .legal_o    (legal),
        .conflict_o (conflict)
    );

    assign next_phase = last_q + 2'd1;
`ifdef TLM_TIMING_CHECK_EN
    assign dwell_inc  = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_ONE;
`endif

    // Next-state logic; TRACK checks run in priority order illegal, hold, advance, skip.
    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        first_partial_d = first_partial_q;
        pulse_d         = '0;
        round_d         = round_q;
`ifdef TLM_TIMING_CHECK_EN
        dwell_d         = dwell_q;
`endif
        case (state_q)
            SYNC: begin
                if (legal) begin
                    state_d         = TRACK;
                    last_d          = code;
                    first_partial_d = 1'b1;
`ifdef TLM_TIMING_CHECK_EN
                    dwell_d         = DWELL_ONE;
`endif
                end
            end
            TRACK: begin
                if (!legal) begin
                    pulse_d[ERR_ILLEGAL]  = 1'b1;
                    pulse_d[ERR_CONFLICT] = conflict;
                    state_d               = SYNC;
                end else if (code == last_q) begin
`ifdef TLM_TIMING_CHECK_EN
                    dwell_d = dwell_inc;
                    if (dwell_inc == DWELL_LIMIT) begin
                        pulse_d[ERR_TIMING] = 1'b1;
                        state_d             = SYNC;
                    end
`endif
                end else if (code == next_phase) begin
`ifdef TLM_TIMING_CHECK_EN
                    // The phase entered from SYNC was seen only partially, so its length is not judged.
                    if (dwell_q != DWELL_NOM && !first_partial_q) begin
                        pulse_d[ERR_TIMING] = 1'b1;
                    end
                    dwell_d = DWELL_ONE;
`endif
                    last_d          = code;
                    first_partial_d = 1'b0;
                    if (last_q == PH_EW_Y) begin
                        round_d = round_q + CNT_W'(1);
                    end
                end else begin
                    pulse_d[ERR_SEQ] = 1'b1;
                    state_d          = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
        status_d = (status_q & ~{4{clr_err}}) | pulse_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ns_q            <= LAMP_RED;
            ew_q            <= LAMP_RED;
            state_q         <= SYNC;
            last_q          <= PH_NS_G;
            first_partial_q <= 1'b1;
            pulse_q         <= '0;
            status_q        <= '0;
            round_q         <= '0;
`ifdef TLM_TIMING_CHECK_EN
            dwell_q         <= '0;
`endif
        end else begin
            ns_q            <= light_north_south;
            ew_q            <= light_east_west;
            state_q         <= state_d;
            last_q          <= last_d;
            first_partial_q <= first_partial_d;
            pulse_q         <= pulse_d;
            status_q        <= status_d;
            round_q         <= round_d;
`ifdef TLM_TIMING_CHECK_EN
            dwell_q         <= dwell_d;
`endif
        end
    end

    assign phase       = last_q;
    assign phase_valid = (state_q == TRACK);
    assign err_pulse   = pulse_q;
    assign err_status  = status_q;
    assign round_count = round_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; expectations follow TLM_TIMING_CHECK_EN
// so the same file covers both builds.
module tb_traffic_light_monitor;

`ifdef TLM_TIMING_CHECK_EN
    localparam bit TIM = 1'b1;
`else
    localparam bit TIM = 1'b0;
`endif

    localparam logic [5:0] ALL_RED = 6'b100_100;
    localparam logic [5:0] P0      = 6'b001_100;
    localparam logic [5:0] P1      = 6'b010_100;
    localparam logic [5:0] P2      = 6'b100_001;
    localparam logic [5:0] P3      = 6'b100_010;
    localparam logic [5:0] BOTH_G  = 6'b001_001;

    typedef struct packed {
        logic [5:0] lamps;
        logic       clr;
        logic [1:0] ph;
        logic       valid;
        logic [3:0] pulse;
        logic [3:0] status;
        logic [7:0] rounds;
    } vec_t;

    logic       clk;
    logic       resetN;
    logic [2:0] lightNs;
    logic [2:0] lightEw;
    logic       clrErr;
    logic [1:0] phaseOut;
    logic       phaseValid;
    logic [3:0] errPulse;
    logic [3:0] errStatus;
    logic [7:0] roundCount;

    int checks;
    int errors;
    vec_t conflictTbl [6];

    traffic_light_monitor #(.PHASE_CYCLES(11), .CNT_W(8)) dut (
        .clk               (clk),
        .reset_n           (resetN),
        .light_north_south (lightNs),
        .light_east_west   (lightEw),
        .clr_err           (clrErr),
        .phase             (phaseOut),
        .phase_valid       (phaseValid),
        .err_pulse         (errPulse),
        .err_status        (errStatus),
        .round_count       (roundCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lampsOf(input int p);
        case (p)
            0:       return P0;
            1:       return P1;
            2:       return P2;
            default: return P3;
        endcase
    endfunction

    // Drives one cycle of lamps and returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [5:0] lamps, input logic clr);
        lightNs = lamps[5:3];
        lightEw = lamps[2:0];
        clrErr  = clr;
        @(posedge clk);
        #1;
    endtask

    // Timing-strobe bit 0 is only expected when the timing checks are built in.
    task automatic checkOutput(input string name, input logic [1:0] ph, input logic valid,
                               input logic [3:0] pulse, input logic [3:0] status,
                               input logic [7:0] rounds);
        logic [3:0] expPulse;
        logic [3:0] expStatus;
        expPulse  = pulse  & {3'b111, TIM};
        expStatus = status & {3'b111, TIM};
        checks++;
        if ({phaseOut, phaseValid, errPulse, errStatus, roundCount} !==
            {ph, valid, expPulse, expStatus, rounds}) begin
            errors++;
            $display("[TB] FAIL %s: got phase=%0d valid=%0b pulse=%b status=%b rounds=%0d, want phase=%0d valid=%0b pulse=%b status=%b rounds=%0d",
                     name, phaseOut, phaseValid, errPulse, errStatus, roundCount,
                     ph, valid, expPulse, expStatus, rounds);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        resetN  = 1'b0;
        lightNs = ALL_RED[5:3];
        lightEw = ALL_RED[2:0];
        clrErr  = 1'b0;

        conflictTbl[0] = '{lamps: P0,     clr: 1'b0, ph: 2'd0, valid: 1'b1, pulse: 4'b0000, status: 4'b0000, rounds: 8'd3};
        conflictTbl[1] = '{lamps: BOTH_G, clr: 1'b0, ph: 2'd0, valid: 1'b1, pulse: 4'b0000, status: 4'b0000, rounds: 8'd3};
        conflictTbl[2] = '{lamps: P0,     clr: 1'b0, ph: 2'd0, valid: 1'b0, pulse: 4'b1100, status: 4'b1100, rounds: 8'd3};
        conflictTbl[3] = '{lamps: P0,     clr: 1'b0, ph: 2'd0, valid: 1'b1, pulse: 4'b0000, status: 4'b1100, rounds: 8'd3};
        conflictTbl[4] = '{lamps: P0,     clr: 1'b1, ph: 2'd0, valid: 1'b1, pulse: 4'b0000, status: 4'b0000, rounds: 8'd3};
        conflictTbl[5] = '{lamps: P0,     clr: 1'b0, ph: 2'd0, valid: 1'b1, pulse: 4'b0000, status: 4'b0000, rounds: 8'd3};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_values", 2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0);
        resetN = 1'b1;
        applyStimulus(ALL_RED, 1'b0);
        checkOutput("all_red_sync", 2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0);

        // Nominal rotation, three full rounds plus the first phase 0 of the fourth.
        for (int k = 0; k < 134; k++) begin
            applyStimulus(lampsOf((k / 11) % 4), 1'b0);
            if (k == 0) begin
                checkOutput("rot_latency", 2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0);
            end else begin
                checkOutput("rotation", 2'(((k - 1) / 11) % 4), 1'b1, 4'b0000, 4'b0000,
                            8'((k - 1) / 44));
            end
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(conflictTbl[i].lamps, conflictTbl[i].clr);
            checkOutput($sformatf("conflict_tbl%0d", i), conflictTbl[i].ph, conflictTbl[i].valid,
                        conflictTbl[i].pulse, conflictTbl[i].status, conflictTbl[i].rounds);
        end

        // Phase 0 skipped straight to phase 2 after an 11-sample phase 0.
        repeat (7) applyStimulus(P0, 1'b0);
        applyStimulus(P2, 1'b0);
        checkOutput("p0_full_length", 2'd0, 1'b1, 4'b0000, 4'b0000, 8'd3);
        applyStimulus(P2, 1'b0);
        checkOutput("seq_jump", 2'd0, 1'b0, 4'b0010, 4'b0010, 8'd3);
        applyStimulus(P2, 1'b0);
        checkOutput("seq_resync", 2'd2, 1'b1, 4'b0000, 4'b0010, 8'd3);
        applyStimulus(P2, 1'b1);
        checkOutput("seq_clear", 2'd2, 1'b1, 4'b0000, 4'b0000, 8'd3);
        applyStimulus(P3, 1'b0);
        applyStimulus(P3, 1'b0);
        checkOutput("partial_not_timed", 2'd3, 1'b1, 4'b0000, 4'b0000, 8'd3);

        // Phase 2 cut to 9 samples after a clean round.
        repeat (9)  applyStimulus(P3, 1'b0);
        repeat (11) applyStimulus(P0, 1'b0);
        repeat (11) applyStimulus(P1, 1'b0);
        repeat (9)  applyStimulus(P2, 1'b0);
        checkOutput("p2_tracking", 2'd2, 1'b1, 4'b0000, 4'b0000, 8'd4);
        applyStimulus(P3, 1'b0);
        applyStimulus(P3, 1'b0);
        checkOutput("short_phase2", 2'd3, 1'b1, 4'b0001, 4'b0001, 8'd4);

        // Phase 1 held for 12 samples.
        repeat (9)  applyStimulus(P3, 1'b0);
        repeat (11) applyStimulus(P0, 1'b0);
        repeat (11) applyStimulus(P1, 1'b0);
        applyStimulus(P1, 1'b0);
        checkOutput("p1_dwell11_ok", 2'd1, 1'b1, 4'b0000, 4'b0001, 8'd5);
        applyStimulus(P1, 1'b0);
        checkOutput("p1_overlong", 2'd1, !TIM, 4'b0001, 4'b0001, 8'd5);

        // Clear colliding with a new sequence error, then reset mid-round.
        applyStimulus(P1, 1'b1);
        checkOutput("clear_before_seq", 2'd1, 1'b1, 4'b0000, 4'b0000, 8'd5);
        applyStimulus(P3, 1'b0);
        applyStimulus(P3, 1'b1);
        checkOutput("seq_beats_clear", 2'd1, 1'b0, 4'b0010, 4'b0010, 8'd5);
        applyStimulus(P3, 1'b0);
        checkOutput("seq_status_kept", 2'd3, 1'b1, 4'b0000, 4'b0010, 8'd5);
        applyStimulus(P3, 1'b0);
        applyStimulus(P0, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("async_reset", 2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0);
        applyStimulus(P0, 1'b0);
        checkOutput("reset_held", 2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0);
        resetN = 1'b1;
        applyStimulus(P0, 1'b0);
        checkOutput("post_reset_sync", 2'd0, 1'b0, 4'b0000, 4'b0000, 8'd0);
        applyStimulus(P0, 1'b0);
        checkOutput("post_reset_track", 2'd0, 1'b1, 4'b0000, 4'b0000, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
